adder_rr_arbiter_seq: RTL

//  Round-robin arbiter that shares one 1-cycle sequential adder (a+b, DATA_WIDTH+1 result) among NUM_REQ requesters.

---
 rtl/adder_rr_arbiter_seq_pkg.sv | 17 +
 rtl/adder_rr_arbiter_seq_adder.sv | 30 +++
 rtl/adder_rr_arbiter_seq_rr_grant_onehot.sv | 37 +++
 rtl/adder_rr_arbiter_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adder_rr_arbiter_seq_pkg.sv
// Shared definitions for the round-robin shared-adder arbiter: tag width derivation,
// result record width and the round-robin pointer advance.
`ifndef ADDER_RR_REC_W
`define ADDER_RR_REC_W(dw, tw) ((tw) + (dw) + 1)
`endif

package adder_rr_arbiter_seq_pkg;

   function automatic int tag_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int rr_next(input int r, input int n);
      return (r + 1 >= n) ? 0 : r + 1;
   endfunction

endpackage

// File: rtl/adder_rr_arbiter_seq_adder.sv
// One-cycle registered adder with carry-out; active-high synchronous reset on the valid only.
module adder_rr_arbiter_seq_adder #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  a_valid,
   input  logic                  b_valid,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  sum_valid,
   output logic [DATA_WIDTH:0]   sum
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_valid <= 1'b0;
      end else if (en) begin
         sum_valid <= a_valid & b_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en && a_valid && b_valid) begin
         sum <= {1'b0, a} + {1'b0, b};
      end
   end

endmodule

// File: rtl/adder_rr_arbiter_seq_rr_grant_onehot.sv
// Rotating-priority picker: one-hot grant to the first requester at or after ptr, wrapping.
module adder_rr_arbiter_seq_rr_grant_onehot #(
   parameter int NUM_REQ   = 4,
   parameter int TAG_WIDTH = 2
) (
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [TAG_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [TAG_WIDTH-1:0] gnt_idx,
   output logic                 gnt_any
);

   logic [TAG_WIDTH:0]   pos;
   logic [TAG_WIDTH-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      pos     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (TAG_WIDTH+1)'(k);
         if (pos >= (TAG_WIDTH+1)'(NUM_REQ)) begin
            pos = pos - (TAG_WIDTH+1)'(NUM_REQ);
         end
         idx = pos[TAG_WIDTH-1:0];
         if (en && !gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_rr_arbiter_seq.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters, with a tagged result FIFO.
// Optional performance counters are built when ADDER_RR_ARB_PERF_EN is defined.
module adder_rr_arbiter_seq
   import adder_rr_arbiter_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int TAG_WIDTH  = tag_width(NUM_REQ),
   parameter int OUT_DEPTH  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_en,
   input  logic [NUM_REQ-1:0]              i_valid,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0] i_data_bus,
   output logic [NUM_REQ-1:0]              o_ready,
   output logic                            o_valid,
   output logic [DATA_WIDTH:0]             o_data_bus,
   output logic [TAG_WIDTH-1:0]            o_tag,
`ifdef ADDER_RR_ARB_PERF_EN
   output logic [NUM_REQ*32-1:0]           o_grant_cnt,
   output logic [31:0]                     o_stall_cnt,
`endif
   input  logic                            i_ready
);

   localparam int SUM_W = DATA_WIDTH + 1;
   localparam int REC_W = `ADDER_RR_REC_W(DATA_WIDTH, TAG_WIDTH);
   localparam int PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW    = $clog2(OUT_DEPTH + 1);

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [TAG_WIDTH-1:0]  ptr_q;
   logic [NUM_REQ-1:0]    gnt;
   logic [TAG_WIDTH-1:0]  gnt_idx;
   logic                  gnt_any;
   logic                  issue_ok;
   logic                  pop;
   logic                  push;
   logic [DATA_WIDTH-1:0] a_p0;
   logic [DATA_WIDTH-1:0] b_p0;
   logic [TAG_WIDTH-1:0]  tag_p1;
   logic [SUM_W-1:0]      sum_p1;
   logic                  vld_p1;
   logic [REC_W-1:0]      mem [OUT_DEPTH];
   logic [REC_W-1:0]      head;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;

   // Stage p0: arbitration and operand select
   assign o_valid  = (count != '0);
   assign pop      = o_valid & i_ready;
   // An in-flight sum already owns a FIFO slot, so it counts against capacity.
   assign issue_ok = rst & i_en &
                     ((32'(count) + 32'(vld_p1) - 32'(pop)) < 32'(OUT_DEPTH));

   adder_rr_arbiter_seq_rr_grant_onehot #(
      .NUM_REQ   (NUM_REQ),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_grant (
      .en      (issue_ok),
      .req     (i_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign o_ready = gnt;

   always_comb begin
      a_p0 = '0;
      b_p0 = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (gnt[r]) begin
            a_p0 = i_data_bus[r*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
            b_p0 = i_data_bus[r*2*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Stage p1: adder output and its tag
   adder_rr_arbiter_seq_adder #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_adder (
      .clk       (clk),
      .rst       (~rst),
      .en        (1'b1),
      .a_valid   (gnt_any),
      .b_valid   (gnt_any),
      .a         (a_p0),
      .b         (b_p0),
      .sum_valid (vld_p1),
      .sum       (sum_p1)
   );

   always_ff @(posedge clk) begin
      if (gnt_any) begin
         tag_p1 <= gnt_idx;
      end
   end

   // Stage p2: result FIFO
   assign push = vld_p1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (gnt_any) begin
            ptr_q <= TAG_WIDTH'(rr_next(int'(gnt_idx), NUM_REQ));
         end
         if (push) begin
            wr_ptr <= wrap_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= wrap_inc(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {tag_p1, sum_p1};
      end
   end

   assign head       = mem[rd_ptr];
   assign o_data_bus = o_valid ? head[SUM_W-1:0] : '0;
   assign o_tag      = o_valid ? head[REC_W-1 -: TAG_WIDTH] : '0;

   push_never_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (count == CW'(OUT_DEPTH))));

`ifdef ADDER_RR_ARB_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   logic [31:0] grant_cnt_q [NUM_REQ];
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            grant_cnt_q[r] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
               grant_cnt_q[r] <= sat_inc(grant_cnt_q[r]);
            end
         end
         if ((|i_valid) && !issue_ok) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign o_grant_cnt[g*32 +: 32] = grant_cnt_q[g];
   end
   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
